seq_bla_subtractor: RTL and testbench
=====================================

# seq_bla_subtractor

Multi-cycle WIDTH-bit subtractor computing a − b − bin four bits per clock through a 4-bit borrow-look-ahead slice. It is the subtraction counterpart to the team's 4-bit carry-look-ahead adder and serves wide datapaths where one narrow slice, reused over several cycles, is preferred to a full-width combinational subtractor. Operands enter and results leave through valid/ready handshakes.

## Interface

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  the result (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow; present only with SUB_OVF_EN.

## Operation

- The FSM has three states: IDLE, CALC and DONE.
- in_ready = 1 only in IDLE with rst_n high. out_valid = 1 only in DONE.
- IDLE: when in_valid && in_ready:
  - latch a, b, bin;
  - clear the step counter k;
  - move to CALC.
- CALC: each cycle the slice processes nibble k, i.e. bits 4k+3 : 4k.
  - The slice borrow input is the latched bin for k = 0, otherwise the registered borrow from step k−1.
  - The slice computes g = ~a & b and p = ~(a ^ b).
  - Borrow chain: br[i+1] = g[i] | (p[i] & br[i]).
  - Slice difference: d = a ^ b ^ br[3:0].
  - d is written into diff[4k+3:4k], and br[4] is registered as the running borrow.
  - When k = N−1: bout ← br[4], and the FSM moves to DONE. Otherwise k increments.
- DONE: diff, bout and ovf hold stable. When out_ready is high, the FSM returns to IDLE.
- New operands are never accepted in DONE, so there is no same-cycle accept-and-retire.
- in_valid in CALC or DONE is ignored. The source must hold its operands until it sees in_ready.
- Latched operands are immune to changes on a, b and bin after acceptance.
- Reset (rst_n low at an edge), including mid-CALC or mid-DONE, gives:
  - state = IDLE, k = 0;
  - diff = 0, bout = 0, ovf = 0, out_valid = 0;
  - any in-flight operation is discarded;
  - in_ready is 0 while rst_n is low and 1 on the first cycle after release.

## Timing

- Accept edge T0 is the edge where in_valid && in_ready.
- Nibble k is registered at edge T0+k+1.
- The DONE state is entered at T0+N, so out_valid is high from cycle T0+N onward.
- Latency from accept to out_valid = N cycles (4 for WIDTH = 16).
- Retire edge: the first edge in DONE with out_ready high. in_ready goes high the following cycle.
- Maximum throughput, with in_valid and out_ready held high: one result per N+2 cycles (6 for WIDTH = 16).
- diff upper nibbles are not meaningful before out_valid. The bench checks diff only while out_valid is high.

## Configuration

- SUB_OVF_EN defined:
  - port ovf exists;
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched a and b;
  - registered together with bout on the last step;
  - valid while out_valid is high.
- SUB_OVF_EN undefined: the ovf port and all of its logic are absent. Everything else is identical.

## Structure

- Package seq_sub_pkg holds:
  - the state encoding: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  - the constant SLICE_W = 4.
- Sub-module bla_sub4 is the combinational 4-bit borrow-look-ahead slice.
  - Ports: a[3:0], b[3:0], bin, d[3:0], bout.
  - It is instantiated once and reused every CALC cycle.
- Top level contains the FSM, the step counter of width clog2(N) (min 1), the operand registers, and the diff shift/insert logic.

## Test plan

- Basic: WIDTH = 16, a = 0x1234, b = 0x0234, bin = 0 → diff = 0x1000, bout = 0, out_valid exactly 4 cycles after accept.
- Wrap: a = 0x0000, b = 0x0001, bin = 0 → diff = 0xFFFF, bout = 1; with SUB_OVF_EN, ovf = 0.
- Borrow-in and overflow: a = 0x8000, b = 0x7FFF, bin = 1 → diff = 0x0000, bout = 0; with SUB_OVF_EN, ovf = 1.
- Backpressure: out_ready held low 5 cycles in DONE → diff, bout and out_valid stable and in_ready = 0 throughout. Retire on the first cycle out_ready is high; in_ready = 1 the next cycle.
- Reset mid-CALC: rst_n low for 1 cycle at step k = 2 → next cycle out_valid = 0, diff = 0, state IDLE. A following operation of 0xFFFF − 0x0001 gives diff = 0xFFFE, bout = 0.
- Back-to-back plus random: in_valid and out_ready high, 1000 random (a, b, bin) triples → results match (a − b − bin) mod 2^16 and the unsigned borrow, with one result per 6 cycles.

Source files
------------

// File: rtl/seq_bla_subtractor_pkg.sv
// seq_sub_pkg: shared state encoding and slice width for the sequential borrow-look-ahead subtractor
package seq_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/seq_bla_subtractor_if.sv
// seq_bla_subtractor_if: operand/result valid-ready bundle
// The ovf signal exists only when SUB_OVF_EN is defined.
interface seq_bla_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;
  modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
`else
  modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout);
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout);
`endif
endinterface

// File: rtl/seq_bla_subtractor_bla_sub4.sv
// bla_sub4: combinational 4-bit borrow-look-ahead subtractor slice
module bla_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [3:0] g, p;
  logic [4:0] br;
  assign g = ~a & b;
  assign p = ~(a ^ b);
  // borrows flattened so every bit depends only on g/p/bin, not on the previous borrow
  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & bin);
  assign br[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & bin);
  assign d = a ^ b ^ br[3:0];
  assign bout = br[4];
endmodule

// File: rtl/seq_bla_subtractor.sv
// seq_bla_subtractor: a - b - bin computed one nibble per clock through a reused 4-bit slice
// Defining SUB_OVF_EN adds the signed-overflow output.
module seq_bla_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_bla_subtractor_if.slave bus
);
  localparam int N  = WIDTH / SLICE_W;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  state_e state_q, state_d;
  logic [KW-1:0] k_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic br_q, bout_q, last, br4;
  logic [SLICE_W-1:0] d;
  // operands shift right each step so the slice always reads the low nibble
  bla_sub4 u_slice (.a(a_q[SLICE_W-1:0]), .b(b_q[SLICE_W-1:0]), .bin(br_q), .d(d), .bout(br4));
  assign last = k_q == KW'(N - 1);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && bus.in_valid) ? CALC :
              (state_q == CALC && last)         ? DONE :
              (state_q == DONE && bus.out_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        br_q <= bus.bin;
        k_q  <= '0;
      end else if (state_q == CALC) begin
        a_q    <= a_q >> SLICE_W;
        b_q    <= b_q >> SLICE_W;
        br_q   <= br4;
        diff_q <= (diff_q >> SLICE_W) | (WIDTH'(d) << (WIDTH - SLICE_W));
        k_q    <= k_q + 1'b1;
        if (last) bout_q <= br4;
      end
    end
  end
`ifdef SUB_OVF_EN
  logic ovf_q;
  // on the last step the slice holds the top nibbles, so bit 3 is each operand's sign
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (state_q == CALC && last) ovf_q <= (a_q[SLICE_W-1] != b_q[SLICE_W-1]) && (d[SLICE_W-1] != a_q[SLICE_W-1]);
  end
  assign bus.ovf = ovf_q;
`endif
  assign bus.in_ready  = state_q == IDLE && rst_n;
  assign bus.out_valid = state_q == DONE;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
endmodule

// File: tb/tb_seq_bla_subtractor.sv
// tb_seq_bla_subtractor: randomized self-checking bench against an arithmetic reference model
module tb_seq_bla_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  seq_bla_subtractor_if #(.WIDTH(16)) bus ();
  seq_bla_subtractor #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {r < 0, 16'(r)};
  endfunction
`ifdef SUB_OVF_EN
  function automatic logic ovf_model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return r < -32768 || r > 32767;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL start_timeout in_ready=%b required 1", bus.in_ready);
    end
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout after %0d cycles", cyc);
    end
  endtask

  task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] exp;
    int cyc;
    exp = model(a, b, bin);
    bus.out_ready = 1'b0;
    start(a, b, bin);
    wait_valid(cyc);
    checks += 3;
    if (cyc !== 4) begin errors++; $display("FAIL %s_latency got %0d required 4", name, cyc); end
    if (bus.diff !== exp[15:0]) begin errors++; $display("FAIL %s_diff got %h required %h", name, bus.diff, exp[15:0]); end
    if (bus.bout !== exp[16]) begin errors++; $display("FAIL %s_bout got %b required %b", name, bus.bout, exp[16]); end
`ifdef SUB_OVF_EN
    checks++;
    if (bus.ovf !== ovf_model(a, b, bin)) begin errors++; $display("FAIL %s_ovf got %b required %b", name, bus.ovf, ovf_model(a, b, bin)); end
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 4;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
    if (bus.diff !== 16'h0) begin errors++; $display("FAIL reset_diff got %h required 0000", bus.diff); end
    if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b required 0", bus.bout); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b required 1", bus.in_ready); end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int cyc;
    exp = model(16'hA5C3, 16'h5A3C, 1'b1);
    bus.out_ready = 1'b0;
    start(16'hA5C3, 16'h5A3C, 1'b1);
    wait_valid(cyc);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b required 1", i, bus.out_valid); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b required 0", i, bus.in_ready); end
      if (bus.diff !== exp[15:0]) begin errors++; $display("FAIL bp_diff cycle %0d got %h required %h", i, bus.diff, exp[15:0]); end
      if (bus.bout !== exp[16]) begin errors++; $display("FAIL bp_bout cycle %0d got %b required %b", i, bus.bout, exp[16]); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_retire_in_ready got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_retire_out_valid got %b required 0", bus.out_valid); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    start(16'h1357, 16'h0246, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_low got %b required 0", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", bus.out_valid); end
    if (bus.diff !== 16'h0) begin errors++; $display("FAIL midrst_diff got %h required 0000", bus.diff); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b required 1", bus.in_ready); end
    test_op("after_reset", 16'hFFFF, 16'h0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] exp;
    int sent = 0, got = 0, cyc = 0, last = -1;
    logic pending = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 1000 && cyc < 8000) begin
      if (bus.in_ready && sent < 1000) begin
        q.push_back(model(bus.a, bus.b, bus.bin));
        sent++;
        pending = 1'b1;
      end
      if (bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_result diff %h", bus.diff);
        end else begin
          exp = q.pop_front();
          if ({bus.bout, bus.diff} !== exp) begin
            errors++;
            $display("FAIL b2b_result %0d got bout %b diff %h required bout %b diff %h", got, bus.bout, bus.diff, exp[16], exp[15:0]);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 6) begin errors++; $display("FAIL b2b_spacing got %0d required 6", cyc - last); end
        end
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (pending) begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.bin = 1'($urandom);
        pending = 1'b0;
        if (sent == 1000) bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (got !== 1000) begin errors++; $display("FAIL b2b_count got %0d required 1000", got); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_op("basic", 16'h1234, 16'h0234, 1'b0);
    test_op("wrap", 16'h0000, 16'h0001, 1'b0);
    test_op("borrow_ovf", 16'h8000, 16'h7FFF, 1'b1);
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
